multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multicycle MIPS control FSM. Consumes the instruction decoder flags (R/I/J type, lw/sw, mult, mflo,
//  jr) plus opcode. Sequences fetch -> decode -> execute -> memory -> writeback over the shared
//  ALU/memory datapath, and drives mux selects and write enables.
//  Handles a memory ready handshake with timeout, and a fixed-latency multiplier wait.
// PARAMETERS
//  MEM_TIMEOUT   16  max cycles waiting for mem_ready before bus_error (>=2)
//  MULT_LATENCY   4  cycles the multiplier needs after mult_start (>=1)
// PORTS
//  clk              in   1  system clock, rising edge
//  reset            in   1  synchronous, active-high
//  opcode           in   6  instruction[31:26]
//  flag_R_type      in   1  decoder: R type
//  flag_I_type      in   1  decoder: I type
//  flag_J_type      in   2  decoder: 1=j/jal, 2=jr
//  flag_lw          in   1  decoder: load
//  flag_sw          in   1  decoder: store flag (also set for lui)
//  mult_operation   in   1  decoder: mult
//  mflo_flag        in   1  decoder: mflo
//  zero             in   1  ALU zero flag
//  mem_ready        in   1  memory completes current access this cycle
//  mem_req          out  1  memory access request, held until mem_ready/timeout
//  IorD             out  1  0=PC address, 1=ALUOut address
//  MemWrite         out  1  memory write strobe (qualified by mem_req)
//  IRWrite          out  1  load instruction register
//  PCWrite          out  1  load PC (unconditional or resolved branch)
//  PCSrc            out  2  0=ALU result, 1=ALUOut (branch), 2=jump target, 3=rs (jr)
//  ALUSrcA          out  1  0=PC, 1=rs
//  ALUSrcB          out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
//  alu_sub_force    out  1  override decoder ALUControl with subtract
//  RegWrite         out  1  register file write enable
//  MemtoReg         out  2  0=ALUOut, 1=mem data, 2=LO, 3=PC (link)
//  link_write       out  1  jal: force write destination to r31
//  mult_start       out  1  one-cycle multiplier start pulse
//  instr_done       out  1  one-cycle pulse on the last cycle of each instruction
//  bus_error        out  1  one-cycle pulse on memory timeout
//  illegal_instr    out  1  one-cycle pulse in DECODE for unsupported opcode
//  state_out        out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 MEM_ADDR=4 MEM_READ=5 MEM_WB=6 MEM_WRITE=7 ALU_WB=8
//   BRANCH=9 JUMP=10 MULT_WAIT=11. Outputs decode combinationally from state (+mem_ready, zero);
//   unlisted outputs are 0.
//  Reset: state=FETCH, counters=0. All outputs are 0 while reset is high. First mem_req is on the
//   cycle after reset falls.
//  FETCH: mem_req=1, IorD=0. On mem_ready: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, PCSrc=0;
//   next state DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=3 (branch target into ALUOut). Next state, first match wins:
//   flag_J_type==2 -> JUMP(jr); flag_J_type==1 && opcode in {02,03} -> JUMP;
//   mult_operation -> MULT_WAIT with mult_start=1; flag_R_type -> EXEC_R;
//   opcode 04/05 -> BRANCH; opcode 23 or 2B -> MEM_ADDR;
//   opcode 08/0A/0C/0D/0F -> EXEC_I (lui goes here despite flag_sw=1);
//   else illegal_instr=1, instr_done=1, next state FETCH.
//  EXEC_R: ALUSrcA=1, ALUSrcB=0 -> ALU_WB. EXEC_I: ALUSrcA=1, ALUSrcB=2 -> ALU_WB.
//  ALU_WB: RegWrite=1, MemtoReg = mflo_flag?2:0, instr_done=1 -> FETCH.
//  MEM_ADDR: ALUSrcA=1, ALUSrcB=2 -> MEM_READ if opcode==23, MEM_WRITE if opcode==2B.
//  MEM_READ: mem_req=1, IorD=1; on mem_ready -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1,
//   instr_done=1 -> FETCH.
//  MEM_WRITE: mem_req=1, IorD=1, MemWrite=1; on mem_ready: instr_done=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, alu_sub_force=1, PCSrc=1, instr_done=1.
//   PCWrite = zero for opcode 04, ~zero for opcode 05 -> FETCH.
//  JUMP: PCWrite=1, instr_done=1, PCSrc = (flag_J_type==2)?3:2.
//   For opcode 03 also RegWrite=1, link_write=1, MemtoReg=3 -> FETCH.
//  MULT_WAIT: counter counts 1..MULT_LATENCY; when it reaches MULT_LATENCY: instr_done=1 -> FETCH.
//   mult_start is high only in the DECODE cycle.
//  Timeout: a wait counter clears on entry to FETCH/MEM_READ/MEM_WRITE and increments each cycle
//   without mem_ready. At MEM_TIMEOUT-1 without ready: bus_error=1, mem_req drops, -> FETCH.
//   No IRWrite/PCWrite/RegWrite occurs, so the PC is not advanced and the same fetch retries.
//   mem_ready on the timeout cycle wins: normal completion, no bus_error.
//  Decoder inputs and opcode are sampled every cycle and must be stable from DECODE to retirement
//   (the IR is not rewritten outside FETCH).
//  Reset asserted mid-instruction: state returns to FETCH on the next edge; no write enable
//   asserts in the reset cycle.
// TESTING
//  add (op 00, funct 20), mem_ready=1 in FETCH -> states 0,1,2,8; RegWrite=1 only in cycle 4; 4 cycles total.
//  lw (op 23), mem_ready delayed 3 cycles in MEM_READ -> mem_req held 4 cycles, then MEM_WB with MemtoReg=1.
//  beq (op 04), zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; with zero=0 -> PCWrite=0, instr_done=1.
//  jal (op 03) -> JUMP: PCSrc=2, RegWrite=1, link_write=1, MemtoReg=3. jr (J=2) -> PCSrc=3, RegWrite=0.
//  mult, MULT_LATENCY=4 -> mult_start one cycle in DECODE, 4 cycles in MULT_WAIT, then FETCH.
//  lui (op 0F, flag_sw=1) -> EXEC_I, never MemWrite. mem_ready never in FETCH -> bus_error at cycle 16,
//   no PCWrite. Reset in MEM_WRITE -> all outputs 0, then FETCH.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle MIPS controller.
// master: the control FSM (reads decoder flags, ALU zero and memory ready;
//         drives mux selects, write enables, status pulses and state debug).
// slave : the datapath/memory side (the mirror image).
interface multicycle_control_unit_if;
  // decoder and datapath status
  logic [5:0] opcode;
  logic       flag_R_type;
  logic       flag_I_type;
  logic [1:0] flag_J_type;
  logic       flag_lw;
  logic       flag_sw;
  logic       mult_operation;
  logic       mflo_flag;
  logic       zero;
  logic       mem_ready;
  // controls
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       alu_sub_force;
  logic       RegWrite;
  logic [1:0] MemtoReg;
  logic       link_write;
  logic       mult_start;
  logic       instr_done;
  logic       bus_error;
  logic       illegal_instr;
  logic [3:0] state_out;

  modport master (
    input  opcode, flag_R_type, flag_I_type, flag_J_type, flag_lw, flag_sw,
           mult_operation, mflo_flag, zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           alu_sub_force, RegWrite, MemtoReg, link_write, mult_start,
           instr_done, bus_error, illegal_instr, state_out
  );

  modport slave (
    output opcode, flag_R_type, flag_I_type, flag_J_type, flag_lw, flag_sw,
           mult_operation, mflo_flag, zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           alu_sub_force, RegWrite, MemtoReg, link_write, mult_start,
           instr_done, bus_error, illegal_instr, state_out
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch -> decode -> execute -> memory ->
// writeback over a shared ALU/memory datapath, with a memory-ready timeout
// and a fixed-latency multiplier wait.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; all outputs forced to 0 while high
//   ctl_io : control bundle (master side), see multicycle_control_unit_if
//
// state     | meaning
// FETCH     | read instruction at PC, load IR, PC += 4
// DECODE    | branch target into ALUOut, dispatch
// EXEC_R    | rs op rt
// EXEC_I    | rs op imm
// MEM_ADDR  | rs + imm address computation
// MEM_READ  | load access
// MEM_WB    | load data into register file
// MEM_WRITE | store access
// ALU_WB    | ALUOut (or LO) into register file
// BRANCH    | beq/bne compare and conditional PC load
// JUMP      | j/jal/jr
// MULT_WAIT | wait for the multiplier
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int MULT_LATENCY = 4
) (
  input logic                          clk,
  input logic                          reset,
  multicycle_control_unit_if.master    ctl_io
);

  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam int MW = $clog2(MULT_LATENCY + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [MW-1:0] MULT_LAST = MW'(MULT_LATENCY);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
    MEM_ADDR = 4'd4, MEM_READ = 4'd5, MEM_WB = 4'd6, MEM_WRITE = 4'd7,
    ALU_WB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, MULT_WAIT = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [MW-1:0] mult_q, mult_d;
  logic          timeout;
  logic          waiting;

  // The controller does not need these decoder flags; opcode disambiguates.
  logic unused_flags;
  assign unused_flags = ^{ctl_io.flag_I_type, ctl_io.flag_lw, ctl_io.flag_sw};

  assign timeout = (wait_q == WAIT_LAST) && !ctl_io.mem_ready;
  assign waiting = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  assign ctl_io.state_out = reset ? 4'd0 : state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      mult_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mult_q  <= mult_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    wait_d               = wait_q;
    mult_d               = '0;
    ctl_io.mem_req       = 1'b0;
    ctl_io.IorD          = 1'b0;
    ctl_io.MemWrite      = 1'b0;
    ctl_io.IRWrite       = 1'b0;
    ctl_io.PCWrite       = 1'b0;
    ctl_io.PCSrc         = 2'd0;
    ctl_io.ALUSrcA       = 1'b0;
    ctl_io.ALUSrcB       = 2'd0;
    ctl_io.alu_sub_force = 1'b0;
    ctl_io.RegWrite      = 1'b0;
    ctl_io.MemtoReg      = 2'd0;
    ctl_io.link_write    = 1'b0;
    ctl_io.mult_start    = 1'b0;
    ctl_io.instr_done    = 1'b0;
    ctl_io.bus_error     = 1'b0;
    ctl_io.illegal_instr = 1'b0;

    if (reset) begin
      state_d = FETCH;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          ctl_io.mem_req = 1'b1;
          if (ctl_io.mem_ready) begin
            ctl_io.IRWrite = 1'b1;
            ctl_io.PCWrite = 1'b1;
            ctl_io.ALUSrcB = 2'd1;
            state_d        = DECODE;
          end else if (timeout) begin
            ctl_io.mem_req   = 1'b0;
            ctl_io.bus_error = 1'b1;
          end
        end
        DECODE: begin
          ctl_io.ALUSrcB = 2'd3;
          if (ctl_io.flag_J_type == 2'd2) begin
            state_d = JUMP;
          end else if (ctl_io.flag_J_type == 2'd1 &&
                       (ctl_io.opcode == 6'h02 || ctl_io.opcode == 6'h03)) begin
            state_d = JUMP;
          end else if (ctl_io.mult_operation) begin
            ctl_io.mult_start = 1'b1;
            state_d           = MULT_WAIT;
          end else if (ctl_io.flag_R_type) begin
            state_d = EXEC_R;
          end else begin
            case (ctl_io.opcode)
              6'h04, 6'h05:                      state_d = BRANCH;
              6'h23, 6'h2B:                      state_d = MEM_ADDR;
              6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: state_d = EXEC_I;
              default: begin
                ctl_io.illegal_instr = 1'b1;
                ctl_io.instr_done    = 1'b1;
                state_d              = FETCH;
              end
            endcase
          end
        end
        EXEC_R: begin
          ctl_io.ALUSrcA = 1'b1;
          state_d        = ALU_WB;
        end
        EXEC_I: begin
          ctl_io.ALUSrcA = 1'b1;
          ctl_io.ALUSrcB = 2'd2;
          state_d        = ALU_WB;
        end
        ALU_WB: begin
          ctl_io.RegWrite   = 1'b1;
          ctl_io.MemtoReg   = ctl_io.mflo_flag ? 2'd2 : 2'd0;
          ctl_io.instr_done = 1'b1;
          state_d           = FETCH;
        end
        MEM_ADDR: begin
          ctl_io.ALUSrcA = 1'b1;
          ctl_io.ALUSrcB = 2'd2;
          state_d        = (ctl_io.opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          ctl_io.mem_req = 1'b1;
          ctl_io.IorD    = 1'b1;
          if (ctl_io.mem_ready) begin
            state_d = MEM_WB;
          end else if (timeout) begin
            ctl_io.mem_req   = 1'b0;
            ctl_io.bus_error = 1'b1;
            state_d          = FETCH;
          end
        end
        MEM_WB: begin
          ctl_io.RegWrite   = 1'b1;
          ctl_io.MemtoReg   = 2'd1;
          ctl_io.instr_done = 1'b1;
          state_d           = FETCH;
        end
        MEM_WRITE: begin
          ctl_io.mem_req  = 1'b1;
          ctl_io.IorD     = 1'b1;
          ctl_io.MemWrite = 1'b1;
          if (ctl_io.mem_ready) begin
            ctl_io.instr_done = 1'b1;
            state_d           = FETCH;
          end else if (timeout) begin
            ctl_io.mem_req   = 1'b0;
            ctl_io.MemWrite  = 1'b0;
            ctl_io.bus_error = 1'b1;
            state_d          = FETCH;
          end
        end
        BRANCH: begin
          ctl_io.ALUSrcA       = 1'b1;
          ctl_io.alu_sub_force = 1'b1;
          ctl_io.PCSrc         = 2'd1;
          ctl_io.instr_done    = 1'b1;
          ctl_io.PCWrite       = (ctl_io.opcode == 6'h05) ? !ctl_io.zero : ctl_io.zero;
          state_d              = FETCH;
        end
        JUMP: begin
          ctl_io.PCWrite    = 1'b1;
          ctl_io.instr_done = 1'b1;
          ctl_io.PCSrc      = (ctl_io.flag_J_type == 2'd2) ? 2'd3 : 2'd2;
          if (ctl_io.opcode == 6'h03) begin
            ctl_io.RegWrite   = 1'b1;
            ctl_io.link_write = 1'b1;
            ctl_io.MemtoReg   = 2'd3;
          end
          state_d = FETCH;
        end
        MULT_WAIT: begin
          if (mult_q == MULT_LAST) begin
            ctl_io.instr_done = 1'b1;
            state_d           = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase

      // Wait counter restarts on every entry to a memory-wait state,
      // including the FETCH -> FETCH retry after a timeout.
      if (state_d != state_q || ctl_io.bus_error) begin
        wait_d = '0;
      end else if (waiting && !ctl_io.mem_ready) begin
        wait_d = wait_q + 1'b1;
      end

      // Multiplier counter holds 1 on the first MULT_WAIT cycle.
      if (state_d == MULT_WAIT) begin
        mult_d = (state_q == MULT_WAIT) ? mult_q + 1'b1 : MW'(1);
      end
    end
  end

endmodule
